// File: rtl/instruction_queue_if.sv
// Bus-side and control-side signals of the instruction queue.
//   master : drives enable/advance/flush/BusMuxOut, observes the head word and status
//   slave  : the queue itself
interface instruction_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  enable;
  logic                  advance;
  logic                  flush;
  logic [DATA_WIDTH-1:0] BusMuxOut;
  logic [DATA_WIDTH-1:0] ControlIn;
  logic [4:0]            opcode;
  logic [3:0]            ra;
  logic [3:0]            rb;
  logic [3:0]            rc;
  logic [DATA_WIDTH-1:0] constant;
  logic                  valid;
  logic                  full;
  logic [CntW-1:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output enable, advance, flush, BusMuxOut,
    input  ControlIn, opcode, ra, rb, rc, constant, valid, full, count, overflow, underflow
  );

  modport slave (
    input  enable, advance, flush, BusMuxOut,
    output ControlIn, opcode, ra, rb, rc, constant, valid, full, count, overflow, underflow
  );
endinterface

// File: rtl/instruction_queue.sv
// Circular FIFO of instruction words between the bus and the control unit.
// The head word is presented on ControlIn (INIT when empty) with Mini SRC field decode.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   q_if  : slave side of instruction_queue_if (push/pop/flush, head word, decode, status)
module instruction_queue #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 4,
  parameter logic [DATA_WIDTH-1:0] INIT        = '0,
  parameter int unsigned           CONST_WIDTH = 19
) (
  input logic                clock,
  input logic                clear,
  instruction_queue_if.slave q_if
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]       r_head;
  logic [PtrW-1:0]       r_tail;
  logic [CntW-1:0]       r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop on a full queue frees the slot the simultaneous push needs.
  assign w_push  = q_if.enable && (!w_full || q_if.advance);
  assign w_pop   = q_if.advance && !w_empty;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (q_if.flush) begin
      // Flush wins over push/pop and leaves the sticky flags alone.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PtrW'(1);
      if (w_pop)  r_head <= r_head + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (q_if.enable && w_full && !q_if.advance) r_overflow  <= 1'b1;
      if (q_if.advance && w_empty)                r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (!q_if.flush && w_push) r_mem[r_tail] <= q_if.BusMuxOut;
  end

  assign w_word = w_empty ? INIT : r_mem[r_head];

  assign q_if.ControlIn = w_word;
  assign q_if.opcode    = w_word[31:27];
  assign q_if.ra        = w_word[26:23];
  assign q_if.rb        = w_word[22:19];
  assign q_if.rc        = w_word[18:15];
  assign q_if.constant  = {{(DATA_WIDTH - CONST_WIDTH){w_word[CONST_WIDTH-1]}},
                           w_word[CONST_WIDTH-1:0]};
  assign q_if.valid     = !w_empty;
  assign q_if.full      = w_full;
  assign q_if.count     = r_count;
  assign q_if.overflow  = r_overflow;
  assign q_if.underflow = r_underflow;
endmodule

// File: tb/tb_instruction_queue.sv
module tb_instruction_queue;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] INIT  = 32'h0;

  logic clock;
  logic clear;

  instruction_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  instruction_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .INIT       (INIT),
    .CONST_WIDTH(19)
  ) dut (
    .clock(clock),
    .clear(clear),
    .q_if (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue plus the two sticky flags.
  logic [31:0] m_q[$];
  bit          m_ovf;
  bit          m_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic model_step(input bit en, input bit adv, input bit fl, input logic [31:0] d);
    bit was_full;
    if (fl) begin
      m_q.delete();
      return;
    end
    was_full = (m_q.size() == DEPTH);
    if (adv) begin
      if (m_q.size() == 0) m_udf = 1;
      else void'(m_q.pop_front());
    end
    if (en) begin
      if (was_full && !adv) m_ovf = 1;
      else m_q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] w;
    logic [31:0] c;
    w = (m_q.size() != 0) ? m_q[0] : INIT;
    c = 32'($signed(w[18:0]));
    check({tag, ".ControlIn"}, bus.ControlIn, w);
    check({tag, ".opcode"},    32'(bus.opcode), 32'(w >> 27));
    check({tag, ".ra"},        32'(bus.ra), (w >> 23) & 32'hF);
    check({tag, ".rb"},        32'(bus.rb), (w >> 19) & 32'hF);
    check({tag, ".rc"},        32'(bus.rc), (w >> 15) & 32'hF);
    check({tag, ".constant"},  bus.constant, c);
    check({tag, ".valid"},     32'(bus.valid), 32'(m_q.size() != 0));
    check({tag, ".full"},      32'(bus.full), 32'(m_q.size() == DEPTH));
    check({tag, ".count"},     32'(bus.count), 32'(m_q.size()));
    check({tag, ".overflow"},  32'(bus.overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
  endtask

  // One clock: drive controls, let the edge happen, compare just after it.
  task automatic step(input string tag, input bit en, input bit adv, input bit fl,
                      input logic [31:0] d);
    bus.enable    = en;
    bus.advance   = adv;
    bus.flush     = fl;
    bus.BusMuxOut = d;
    model_step(en, adv, fl, d);
    @(posedge clock);
    #1;
    bus.enable  = 1'b0;
    bus.advance = 1'b0;
    bus.flush   = 1'b0;
    check_all(tag);
  endtask

  // Drop clear between edges and check that outputs react without a clock.
  task automatic async_reset(input string tag);
    #2;
    clear = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #1;
    clear = 1'b1;
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.advance   = 1'b0;
    bus.flush     = 1'b0;
    bus.BusMuxOut = '0;
    clear         = 1'b0;
    model_reset();
    #12;
    check_all("reset_low");
    clear = 1'b1;
    #1;
    check_all("reset_rel");

    // Pop from empty
    step("pop_empty", 0, 1, 0, 0);
    check("pop_empty.udf_lit", 32'(bus.underflow), 32'd1);

    // Single load / decode
    step("load", 1, 0, 0, 32'h1A8C_0007);
    check("load.opcode_lit", 32'(bus.opcode), 32'h3);
    check("load.ra_lit", 32'(bus.ra), 32'h5);
    check("load.rb_lit", 32'(bus.rb), 32'h1);
    check("load.rc_lit", 32'(bus.rc), 32'h8);
    // Bit 18 of this word is set, so the immediate is negative.
    check("load.const_lit", bus.constant, 32'hFFFC_0007);
    step("load_pop", 0, 1, 0, 0);

    // Negative constant
    step("neg", 1, 0, 0, 32'h0004_0000);
    check("neg.const_lit", bus.constant, 32'hFFFC_0000);
    step("neg_pop", 0, 1, 0, 0);

    // Fill, overflow, ordered drain
    step("fill0", 1, 0, 0, 32'h11);
    step("fill1", 1, 0, 0, 32'h22);
    step("fill2", 1, 0, 0, 32'h33);
    step("fill3", 1, 0, 0, 32'h44);
    check("fill.full_lit", 32'(bus.full), 32'd1);
    step("ovf", 1, 0, 0, 32'h55);
    check("ovf.flag_lit", 32'(bus.overflow), 32'd1);
    check("ovf.count_lit", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, 0);
    check("drain.valid_lit", 32'(bus.valid), 32'd0);

    // Simultaneous push/pop on a full queue (tail wraps)
    async_reset("rst1");
    step("f2_0", 1, 0, 0, 32'h11);
    step("f2_1", 1, 0, 0, 32'h22);
    step("f2_2", 1, 0, 0, 32'h33);
    step("f2_3", 1, 0, 0, 32'h44);
    step("pushpop_full", 1, 1, 0, 32'h55);
    check("pushpop_full.head_lit", bus.ControlIn, 32'h22);
    check("pushpop_full.ovf_lit", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) step("drain2", 0, 1, 0, 0);

    // Push+pop on empty: pop ignored with underflow, push accepted
    step("pushpop_empty", 1, 1, 0, 32'h77);
    step("pp_pop", 0, 1, 0, 0);

    // Flush priority, then async reset mid-cycle
    step("fl0", 1, 0, 0, 32'h1);
    step("fl1", 1, 0, 0, 32'h2);
    step("fl2", 1, 0, 0, 32'h3);
    step("flush", 1, 1, 1, 32'h99);
    check("flush.count_lit", 32'(bus.count), 32'd0);
    step("post_flush", 1, 0, 0, 32'h66);
    async_reset("rst_mid");
    check("rst_mid.count_lit", 32'(bus.count), 32'd0);

    // Randomized traffic with occasional flush and async reset
    for (int i = 0; i < 400; i++) begin
      bit en, adv, fl;
      en  = ($urandom_range(0, 99) < 55);
      adv = ($urandom_range(0, 99) < 45);
      fl  = ($urandom_range(0, 31) == 0);
      step("rand", en, adv, fl, $urandom);
      if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
